// File: rtl/rc4_ksa_sequencer.sv
// rc4_ksa_sequencer: RC4 key-scheduling sequencer driving a single-port 256x8 S-RAM; FILL phase present only when KSA_FILL_PHASE_EN is defined
module rc4_ksa_sequencer #(
  parameter  int KEY_BYTES = 3,
  localparam int KEY_W     = 8 * KEY_BYTES,
  localparam int KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_data,
  output logic             mem_wren,
  input  logic [7:0]       mem_q
);
  typedef enum logic [3:0] {IDLE, FILL, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, kb;
  logic [KW-1:0]    k_q, k_d;
  logic [KEY_W-1:0] key_q, key_d;
  // state and datapath registers; reset abandons any run in progress
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end
  // key byte selected by k = i mod KEY_BYTES; byte 0 is the most significant
  always_comb begin
    kb = '0;
    for (int n = 0; n < KEY_BYTES; n++)
      if (k_q == n[KW-1:0]) kb = key_q[KEY_W-1-8*n -: 8];
  end
  // next-state and register updates for the fill/shuffle sequence
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    case (state_q)
      IDLE: if (start) begin
        key_d = key;
        i_d   = '0;
        j_d   = '0;
        k_d   = '0;
`ifdef KSA_FILL_PHASE_EN
        state_d = FILL;
`else
        state_d = RD_I;
`endif
      end
`ifdef KSA_FILL_PHASE_EN
      FILL: begin
        i_d     = i_q + 8'd1;
        state_d = (i_q == 8'hFF) ? RD_I : FILL;
      end
`endif
      RD_I:  state_d = LAT_I;
      LAT_I: begin
        si_d    = mem_q;
        j_d     = j_q + mem_q + kb;
        state_d = RD_J;
      end
      RD_J:  state_d = LAT_J;
      LAT_J: begin
        sj_d    = mem_q;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        i_d     = i_q + 8'd1;
        k_d     = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
        state_d = (i_q == 8'hFF) ? DONE : RD_I;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Moore decode of handshake and RAM port from state and registers
  always_comb begin
    busy     = (state_q != IDLE) && (state_q != DONE);
    done     = (state_q == DONE);
    mem_wren = (state_q == FILL) || (state_q == WR_I) || (state_q == WR_J);
    mem_addr = (state_q == RD_J || state_q == LAT_J || state_q == WR_J) ? j_q :
               (state_q == IDLE || state_q == DONE) ? 8'd0 : i_q;
    mem_data = (state_q == FILL) ? i_q : (state_q == WR_I) ? sj_q : (state_q == WR_J) ? si_q : 8'd0;
  end
endmodule

// File: tb/tb_rc4_ksa_sequencer.sv
// tb_rc4_ksa_sequencer: scoreboard bench for the RC4 KSA sequencer against a behavioural RAM and KSA model
module tb_rc4_ksa_sequencer;
`ifdef KSA_FILL_PHASE_EN
  localparam int LAT  = 1792;
  localparam int FILL = 1;
`else
  localparam int LAT  = 1536;
  localparam int FILL = 0;
`endif
  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic [23:0] key      = '0;
  logic        busy, done, mem_wren;
  logic [7:0]  mem_addr, mem_data;
  logic [7:0]  mem_q    = '0;
  logic [7:0]  ram [256];
  logic [7:0]  ms  [256];
  logic [15:0] exp_w [$];
  int          exp_d [$];
  logic [15:0] ew;
  int          ed;
  int          checks = 0, errors = 0, cyc = 0;
  bit          sb_on = 1'b0, preload = 1'b0;
  logic [7:0]  pre_x = '0;

  rc4_ksa_sequencer #(.KEY_BYTES(3)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .key(key),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // single-port RAM, registered read, plus cycle counter
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (preload) for (int n = 0; n < 256; n++) ram[n] <= 8'(n) ^ pre_x;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every RAM write and every done pulse is checked against the queues
  always @(negedge CLOCK_50) if (sb_on) begin
    if (mem_wren) begin
      if (exp_w.size() == 0) chk("write_unexpected", {mem_addr, mem_data}, -1);
      else begin
        ew = exp_w.pop_front();
        chk("write_addr_data", {mem_addr, mem_data}, ew);
      end
    end
    if (done) begin
      if (exp_d.size() == 0) chk("done_unexpected", cyc, -1);
      else begin
        ed = exp_d.pop_front();
        chk("done_cycle", cyc, ed);
      end
    end
  end

  // reference RC4 KSA: expected write stream and final S
  task automatic build(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] j, t;
    j = '0;
    exp_w.delete();
    if (FILL != 0) for (int n = 0; n < 256; n++) exp_w.push_back({8'(n), 8'(n)});
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    for (int i = 0; i < 256; i++) begin
      j = j + s[i] + k[23-8*(i%3) -: 8];
      exp_w.push_back({8'(i), s[j]});
      exp_w.push_back({j, s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int n = 0; n < 256; n++) ms[n] = s[n];
  endtask

  task automatic run(input logic [23:0] k, input int abort_at, input int glitch_at);
    int st, bad;
    @(negedge CLOCK_50);
    pre_x = (FILL != 0) ? 8'h5A : 8'h00;
    preload = 1'b1;
    @(posedge CLOCK_50);
    #1 preload = 1'b0;
    build(k);
    sb_on = 1'b1;
    @(negedge CLOCK_50);
    key = k;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    st = cyc;
    exp_d.push_back(st + LAT);
    key = ~k;
    @(negedge CLOCK_50);
    chk("busy_after_start", busy, 1);
    chk("first_addr", mem_addr, 0);
    chk("first_wren", mem_wren, FILL);
    for (int n = 1; n <= LAT + 20 && !done; n++) begin
      if (n == glitch_at) start = 1'b1;
      if (n == abort_at) begin
        sb_on = 1'b0;
        reset_n = 1'b0;
      end
      @(negedge CLOCK_50);
      start = 1'b0;
      if (n == glitch_at) chk("busy_during_ignored_start", busy, 1);
      if (n == abort_at) begin
        chk("abort_busy", busy, 0);
        chk("abort_wren", mem_wren, 0);
        chk("abort_done", done, 0);
        reset_n = 1'b1;
        exp_w.delete();
        exp_d.delete();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("idle_after_abort_busy", busy, 0);
        return;
      end
    end
    chk("done_seen", done, 1);
    @(negedge CLOCK_50);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wren", mem_wren, 0);
    sb_on = 1'b0;
    chk("writes_outstanding", exp_w.size(), 0);
    chk("done_outstanding", exp_d.size(), 0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (ram[n] !== ms[n]) bad++;
    chk("final_ram_mismatches", bad, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLOCK_50);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_wren", mem_wren, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_data", mem_data, 0);
    end
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    chk("post_reset_busy", busy, 0);
    run(24'h030201, 0, 500);
    run(24'h000000, 0, 0);
    run(24'h030201, 1000, 0);
    run(24'h1A2B3C, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
